// File: rtl/infrared_tx.sv
// infrared_tx: serialises a 32-bit frame onto an active-low infrared line.
// The frame is a lead pulse, 32 pulse-distance coded bits sent LSB first,
// a stop pulse and a trailing high guard interval. All durations are in clk
// cycles. GUARD is expected to be at least 510.
module infrared_tx #(
  parameter int unsigned LEAD_LOW  = 360,
  parameter int unsigned LEAD_HIGH = 180,
  parameter int unsigned BIT_LOW   = 22,
  parameter int unsigned ZERO_HIGH = 22,
  parameter int unsigned ONE_HIGH  = 54,
  parameter int unsigned GUARD     = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data,
  output logic        E,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEAD_L  = 3'd1,
    LEAD_H  = 3'd2,
    BIT_L   = 3'd3,
    BIT_H   = 3'd4,
    STOP_L  = 3'd5,
    GUARD_H = 3'd6
  } state_t;

  // The counter is loaded with duration-1 so a phase lasts exactly its duration.
  localparam logic [15:0] LEAD_LOW_M1  = 16'(LEAD_LOW - 1);
  localparam logic [15:0] LEAD_HIGH_M1 = 16'(LEAD_HIGH - 1);
  localparam logic [15:0] BIT_LOW_M1   = 16'(BIT_LOW - 1);
  localparam logic [15:0] ZERO_HIGH_M1 = 16'(ZERO_HIGH - 1);
  localparam logic [15:0] ONE_HIGH_M1  = 16'(ONE_HIGH - 1);
  localparam logic [15:0] GUARD_M1     = 16'(GUARD - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [5:0]  idx, idx_nx;
  logic [31:0] shreg, shreg_nx;
  logic        e_nx, busy_nx, done_nx;

  // Next-state, counter, bit index and shift register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nx = data;
          idx_nx   = 6'd0;
          cnt_nx   = LEAD_LOW_M1;
          state_nx = LEAD_L;
        end
      end
      LEAD_L: begin
        if (cnt == 16'd0) begin
          cnt_nx   = LEAD_HIGH_M1;
          state_nx = LEAD_H;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      LEAD_H: begin
        if (cnt == 16'd0) begin
          cnt_nx   = BIT_LOW_M1;
          state_nx = BIT_L;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      BIT_L: begin
        if (cnt == 16'd0) begin
          // The current bit always sits in shreg[0]; its value picks the high time.
          cnt_nx   = shreg[0] ? ONE_HIGH_M1 : ZERO_HIGH_M1;
          state_nx = BIT_H;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      BIT_H: begin
        if (cnt == 16'd0) begin
          idx_nx   = idx + 6'd1;
          shreg_nx = {1'b0, shreg[31:1]};
          cnt_nx   = BIT_LOW_M1;
          // The index stops at 32 and is only cleared by the next start.
          state_nx = (idx_nx == 6'd32) ? STOP_L : BIT_L;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      STOP_L: begin
        if (cnt == 16'd0) begin
          cnt_nx   = GUARD_M1;
          state_nx = GUARD_H;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      GUARD_H: begin
        if (cnt == 16'd0) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: begin
        cnt_nx   = 16'd0;
        state_nx = IDLE;
      end
    endcase
    // Outputs are registered from the next state so E changes with the state.
    e_nx    = !(state_nx inside {LEAD_L, BIT_L, STOP_L});
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers; reset forces the idle line level at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 6'd0;
      shreg <= 32'd0;
      E     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      E     <= e_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

endmodule
